// File: rtl/cpu_mem_responder.sv
// CPU-side memory responder: 2 KB work RAM (mirrored), PRG ROM pass-through,
// and a $4014-triggered sprite DMA that halts the CPU and copies a 256-byte
// page into OAM, one byte every two cycles, aligned to the even parity cycle.
module cpu_mem_responder (
   input  logic        clk_ph1,
   input  logic        rst,
   input  logic [15:0] Addr_bus,
   input  logic [7:0]  Data_bus_out,
   input  logic        R_nW,
   output logic [7:0]  Data_bus_in,
   output logic        rdy,
   output logic [14:0] prg_addr,
   input  logic [7:0]  prg_data,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data,
   output logic        oam_we
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   state_t      state, state_nx;
   logic        parity;
   logic [7:0]  page, idx, dma_buf, dma_byte;
   logic [15:0] dma_src;
   logic        cpu_wr, dma_trig;
   logic [7:0]  ram [0:2047];

   // CPU writes only take effect while the CPU is not halted
   assign cpu_wr   = ~R_nW & (state == IDLE);
   assign dma_trig = cpu_wr & (Addr_bus == 16'h4014);
   assign dma_src  = {page, idx};

   // ROM address follows the DMA source only while a DMA read is in flight
   assign prg_addr = (state == READ) ? dma_src[14:0] : Addr_bus[14:0];

   // CPU read decode: RAM (mirrored x4), PRG ROM, everything else reads 0
   always_comb begin
      Data_bus_in = 8'h00;
      if (Addr_bus[15:13] == 3'b000) Data_bus_in = ram[Addr_bus[10:0]];
      else if (Addr_bus[15])         Data_bus_in = prg_data;
   end

   // DMA source decode uses the same map as the CPU
   always_comb begin
      dma_byte = 8'h00;
      if (dma_src[15:13] == 3'b000) dma_byte = ram[dma_src[10:0]];
      else if (dma_src[15])         dma_byte = prg_data;
   end

   // work RAM write port; contents are deliberately not reset
   always_ff @(posedge clk_ph1) begin
      if (cpu_wr && !rst && Addr_bus[15:13] == 3'b000)
         ram[Addr_bus[10:0]] <= Data_bus_out;
   end

   // DMA sequencing: HALT picks ALIGN when needed so READ lands on parity 0
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (dma_trig) state_nx = HALT;
         HALT:    state_nx = parity ? READ : ALIGN;
         ALIGN:   state_nx = READ;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = (idx == 8'hFF) ? IDLE : READ;
         default: state_nx = IDLE;
      endcase
   end

   // state, parity and DMA datapath registers
   always_ff @(posedge clk_ph1 or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         parity  <= 1'b0;
         page    <= 8'h00;
         idx     <= 8'h00;
         dma_buf <= 8'h00;
      end else begin
         state  <= state_nx;
         parity <= ~parity;
         if (dma_trig) begin
            page <= Data_bus_out;
            idx  <= 8'h00;
         end
         if (state == READ)  dma_buf <= dma_byte;
         if (state == WRITE) idx <= idx + 8'd1;
      end
   end

   assign rdy      = (state == IDLE);
   assign oam_we   = (state == WRITE);
   assign oam_addr = idx;
   assign oam_data = dma_buf;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: memory map, mirroring, DMA timing
// for both parity alignments, ROM/unmapped DMA sources, mid-DMA reset.
module tb_cpu_mem_responder;

   logic        clk_ph1 = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] Addr_bus = 16'h1234;
   logic [7:0]  Data_bus_out = 8'h00;
   logic        R_nW = 1'b1;
   logic [7:0]  Data_bus_in;
   logic        rdy;
   logic [14:0] prg_addr;
   logic [7:0]  prg_data;
   logic [7:0]  oam_addr, oam_data;
   logic        oam_we;

   logic        prg_mode = 1'b0;
   logic [7:0]  prg_val = 8'h00;
   logic        tb_par;
   logic [7:0]  exp_mem [256];
   int          checks = 0;
   int          errors = 0;

   cpu_mem_responder dut (
      .clk_ph1(clk_ph1), .rst(rst), .Addr_bus(Addr_bus), .Data_bus_out(Data_bus_out),
      .R_nW(R_nW), .Data_bus_in(Data_bus_in), .rdy(rdy), .prg_addr(prg_addr),
      .prg_data(prg_data), .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we)
   );

   // ROM model: fixed value, or a pattern derived from the address
   assign prg_data = prg_mode ? (prg_addr[7:0] ^ {1'b0, prg_addr[14:8]}) : prg_val;

   always #5 clk_ph1 = ~clk_ph1;

   // expected parity: 0 out of reset, toggles every clock
   always @(posedge clk_ph1 or posedge rst)
      if (rst) tb_par <= 1'b0;
      else     tb_par <= ~tb_par;

   // called at a negedge, returns at a negedge
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      Addr_bus = a; Data_bus_out = d; R_nW = 1'b0;
      @(posedge clk_ph1);
      @(negedge clk_ph1);
      R_nW = 1'b1;
   endtask

   task automatic run_dma(input logic [7:0] pg, input logic align, input logic cpu_wr_during,
                          input string name);
      int lowc, pulses, guard;
      while (tb_par !== align) @(negedge clk_ph1);
      cpu_write(16'h4014, pg);
      if (cpu_wr_during) R_nW = 1'b0;
      else Addr_bus = 16'h0000;
      lowc = 0; pulses = 0; guard = 0;
      while (rdy === 1'b0 && guard < 1000) begin
         lowc++; guard++;
         if (oam_we === 1'b1) begin
            checks++;
            if (oam_addr !== pulses[7:0] || oam_data !== exp_mem[pulses[7:0]]) begin
               errors++;
               $display("FAIL %s pulse %0d: got addr %h data %h, want addr %h data %h",
                        name, pulses, oam_addr, oam_data, pulses[7:0], exp_mem[pulses[7:0]]);
            end
            pulses++;
         end
         if (cpu_wr_during) begin
            Addr_bus = guard[0] ? 16'h4014 : 16'h0010;
            Data_bus_out = 8'hFF;
         end
         @(negedge clk_ph1);
      end
      R_nW = 1'b1;
      checks++;
      if (lowc != (align ? 514 : 513)) begin
         errors++;
         $display("FAIL %s rdy_low: got %0d cycles, want %0d", name, lowc, align ? 514 : 513);
      end
      checks++;
      if (pulses != 256) begin
         errors++;
         $display("FAIL %s pulses: got %0d, want 256", name, pulses);
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if (rdy !== 1'b1 || oam_we !== 1'b0 || oam_addr !== 8'h00 || oam_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got rdy %b we %b addr %h data %h, want 1 0 00 00",
                  rdy, oam_we, oam_addr, oam_data);
      end
      checks++;
      if (prg_addr !== 15'h1234) begin
         errors++;
         $display("FAIL reset_prg_addr: got %h, want 1234", prg_addr);
      end
      @(negedge clk_ph1); @(negedge clk_ph1);
      rst = 1'b0;
   endtask

   task automatic test_mirror;
      cpu_write(16'h0005, 8'h3C);
      Addr_bus = 16'h0805; #1;
      checks++;
      if (Data_bus_in !== 8'h3C) begin
         errors++; $display("FAIL mirror_0805: got %h, want 3c", Data_bus_in);
      end
      Addr_bus = 16'h1805; #1;
      checks++;
      if (Data_bus_in !== 8'h3C) begin
         errors++; $display("FAIL mirror_1805: got %h, want 3c", Data_bus_in);
      end
      @(negedge clk_ph1);
   endtask

   task automatic test_map;
      int pulses;
      prg_val = 8'hA7;
      Addr_bus = 16'hC123; #1;
      checks++;
      if (prg_addr !== 15'h4123 || Data_bus_in !== 8'hA7) begin
         errors++;
         $display("FAIL prg_read: got addr %h data %h, want 4123 a7", prg_addr, Data_bus_in);
      end
      Addr_bus = 16'h5000; #1;
      checks++;
      if (Data_bus_in !== 8'h00) begin
         errors++; $display("FAIL unmapped_read: got %h, want 00", Data_bus_in);
      end
      @(negedge clk_ph1);
      cpu_write(16'h0000, 8'h11);
      pulses = 0;
      fork
         begin
            cpu_write(16'h8000, 8'h99);
            cpu_write(16'h5000, 8'h77);
            cpu_write(16'h2000, 8'h66);
         end
         repeat (4) begin
            @(negedge clk_ph1);
            if (oam_we === 1'b1 || rdy !== 1'b1) pulses++;
         end
      join
      Addr_bus = 16'h0000; #1;
      checks++;
      if (Data_bus_in !== 8'h11) begin
         errors++; $display("FAIL write_rom_no_effect: ram[0] got %h, want 11", Data_bus_in);
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL write_rom_no_oam: got %0d busy/we cycles, want 0", pulses);
      end
      @(negedge clk_ph1);
   endtask

   task automatic test_dma_ram;
      for (int i = 0; i < 256; i++) begin
         cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'h55);
         exp_mem[i] = 8'(i) ^ 8'h55;
      end
      cpu_write(16'h0010, 8'h12);
      run_dma(8'h02, 1'b0, 1'b0, "dma_even");
      run_dma(8'h02, 1'b1, 1'b1, "dma_odd_cpuwr");
      Addr_bus = 16'h0010; #1;
      checks++;
      if (Data_bus_in !== 8'h12) begin
         errors++; $display("FAIL dma_cpu_write_ignored: ram[10] got %h, want 12", Data_bus_in);
      end
      @(negedge clk_ph1);
   endtask

   task automatic test_dma_sources;
      prg_mode = 1'b1;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h05;
      run_dma(8'h85, 1'b0, 1'b0, "dma_prg");
      prg_mode = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
      run_dma(8'h30, 1'b1, 1'b0, "dma_unmapped");
   endtask

   task automatic test_reset_mid_dma;
      int pulses, guard, stray;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h55;
      cpu_write(16'h4014, 8'h02);
      Addr_bus = 16'h0000;
      pulses = 0; guard = 0;
      while (pulses < 100 && guard < 1000) begin
         @(negedge clk_ph1);
         guard++;
         if (oam_we === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 100) begin
         errors++; $display("FAIL abort_reach_100: got %0d pulses, want 100", pulses);
      end
      rst = 1'b1; #1;
      checks++;
      if (rdy !== 1'b1 || oam_we !== 1'b0 || oam_addr !== 8'h00) begin
         errors++;
         $display("FAIL abort_immediate: got rdy %b we %b addr %h, want 1 0 00", rdy, oam_we, oam_addr);
      end
      @(negedge clk_ph1);
      rst = 1'b0;
      stray = 0;
      repeat (600) begin
         @(negedge clk_ph1);
         if (oam_we !== 1'b0 || rdy !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++; $display("FAIL abort_no_pulses: got %0d active cycles, want 0", stray);
      end
      run_dma(8'h02, 1'b0, 1'b0, "dma_restart");
   endtask

   initial begin
      test_reset();
      test_mirror();
      test_map();
      test_dma_ram();
      test_dma_sources();
      test_reset_mid_dma();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
